imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_pkg.sv | 22 ++
 rtl/imm_extend_pipe_if.sv | 33 +++
 rtl/imm_extend_pipe_core.sv | 46 ++++
 rtl/imm_extend_pipe.sv | 103 ++++++++++
 tb/tb_imm_extend_pipe.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// imm_extend_pipe_pkg
//   Shared definitions for the immediate-extension pipeline.
//   Holds the extension mode encodings carried on In_Mode and the
//   occupancy state encoding used by the two-entry output buffer.
package imm_extend_pipe_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SIGN   = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_BRANCH = 2'd2,
    MODE_UPPER  = 2'd3
  } modeE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateE;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if
//   Valid/ready bundle between a producer of raw immediates and a
//   consumer of extended words.
//   Input side : In_Valid, In_Ready, In_Imm[IN_W], In_Mode[2]
//   Output side: Out_Valid, Out_Ready, Out_Data[OUT_W]
//   master : the environment (drives requests, accepts results)
//   slave  : the extension pipeline
interface imm_extend_pipe_if
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic              In_Valid;
  logic              In_Ready;
  logic [IN_W-1:0]   In_Imm;
  logic [MODE_W-1:0] In_Mode;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [OUT_W-1:0]  Out_Data;

  modport master (
    output In_Valid, In_Imm, In_Mode, Out_Ready,
    input  In_Ready, Out_Valid, Out_Data
  );

  modport slave (
    input  In_Valid, In_Imm, In_Mode, Out_Ready,
    output In_Ready, Out_Valid, Out_Data
  );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// imm_extend_core
//   Purely combinational immediate extender.
//   imm    : raw IN_W-bit immediate field
//   mode   : extension mode (sign, zero, branch offset, upper)
//   result : OUT_W-bit extended word
module imm_extend_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  result
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] branchOff;
  logic [OUT_W-1:0] upperImm;
  modeE             modeSel;

  // All four candidate results are formed in parallel and the mode
  // picks one. The branch form is a word offset, so the sign-extended
  // value is scaled by four and simply loses its top two bits.
  assign signExt   = {{EXT_W{imm[IN_W-1]}}, imm};
  assign zeroExt   = {{EXT_W{1'b0}}, imm};
  assign branchOff = signExt << 2;
  assign upperImm  = {imm, {EXT_W{1'b0}}};
  assign modeSel   = modeE'(mode);

  // Mode select; every encoding of the two-bit mode is a legal mode.
  always_comb begin
    result = '0;
    case (modeSel)
      MODE_SIGN:   result = signExt;
      MODE_ZERO:   result = zeroExt;
      MODE_BRANCH: result = branchOff;
      MODE_UPPER:  result = upperImm;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Extends immediates on the way in and buffers up to two results in
//   a main/skid register pair so the producer never sees a
//   combinational path from Out_Ready.
//   Clk   : sole clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : valid/ready bundle (slave side), see imm_extend_pipe_if
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  imm_extend_pipe_if.slave bus
);

  stateE            state;
  stateE            nextState;
  logic [OUT_W-1:0] mainReg;
  logic [OUT_W-1:0] mainNext;
  logic [OUT_W-1:0] skidReg;
  logic [OUT_W-1:0] skidNext;
  logic [OUT_W-1:0] extResult;
  logic             inReadyReg;
  logic             outValidReg;
  logic             inXfer;
  logic             outXfer;

  // Extension happens before storage, so both buffer entries already
  // hold the finished word and the skid-to-main move is a plain copy.
  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) extendCore (
    .imm    (bus.In_Imm),
    .mode   (bus.In_Mode),
    .result (extResult)
  );

  assign inXfer        = bus.In_Valid  && inReadyReg;
  assign outXfer       = outValidReg   && bus.Out_Ready;
  assign bus.In_Ready  = inReadyReg;
  assign bus.Out_Valid = outValidReg;
  assign bus.Out_Data  = mainReg;

  // Occupancy bookkeeping. Main always holds the oldest result; the
  // skid only fills when main is occupied and not leaving this cycle.
  // In ONE with traffic on both sides the old result leaves and the new
  // one lands straight in main, which is what gives full throughput.
  always_comb begin
    nextState = state;
    mainNext  = mainReg;
    skidNext  = skidReg;
    case (state)
      EMPTY: begin
        if (inXfer) begin
          nextState = ONE;
          mainNext  = extResult;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          mainNext = extResult;
        end else if (inXfer) begin
          nextState = TWO;
          skidNext  = extResult;
        end else if (outXfer) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (outXfer) begin
          nextState = ONE;
          mainNext  = skidReg;
        end
      end
      default: begin
        nextState = EMPTY;
      end
    endcase
  end

  // State and data registers. The handshake outputs are flops loaded
  // from the next state so neither one depends on this cycle's inputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= EMPTY;
      mainReg     <= '0;
      skidReg     <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
    end else begin
      state       <= nextState;
      mainReg     <= mainNext;
      skidReg     <= skidNext;
      inReadyReg  <= (nextState != TWO);
      outValidReg <= (nextState != EMPTY);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Self-checking bench for imm_extend_pipe (IN_W=16, OUT_W=32) plus a
//   standalone 26-bit extender core. Expected results come from an
//   arithmetic reference and a two-deep FIFO model of the buffer.
module tb_imm_extend_pipe;

  logic Clk;
  logic Reset;

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] expectQ[$];

  logic [25:0] imm26;
  logic [1:0]  mode26;
  logic [31:0] res26;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_extend_pipe #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  imm_extend_core #(
    .IN_W  (26),
    .OUT_W (32)
  ) core26 (
    .imm    (imm26),
    .mode   (mode26),
    .result (res26)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference extension from the arithmetic meaning of each mode:
  // the field read as a signed integer, optionally scaled, then the
  // low 32 bits kept.
  function automatic logic [31:0] refExt(input longint imm, input int inW, input int mode);
    longint sv;
    longint r;
    sv = (imm >= (longint'(1) << (inW - 1))) ? imm - (longint'(1) << inW) : imm;
    case (mode)
      0:       r = sv;
      1:       r = imm;
      2:       r = sv * 4;
      default: r = imm * (longint'(1) << (32 - inW));
    endcase
    return r[31:0];
  endfunction

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Entered at a falling edge: check the outputs against the model,
  // drive this cycle's inputs, advance the model as the coming rising
  // edge will, then wait for the next falling edge.
  task automatic applyStimulus(input logic inValid, input logic [15:0] imm,
                               input logic [1:0] mode, input logic outReady);
    bit inX;
    bit outX;
    checkOutput("inReady", {31'd0, bus.In_Ready}, {31'd0, (expectQ.size() < 2)});
    checkOutput("outValid", {31'd0, bus.Out_Valid}, {31'd0, (expectQ.size() > 0)});
    if (expectQ.size() > 0)
      checkOutput("outData", bus.Out_Data, expectQ[0]);
    bus.In_Valid  = inValid;
    bus.In_Imm    = imm;
    bus.In_Mode   = mode;
    bus.Out_Ready = outReady;
    outX = (expectQ.size() > 0) && outReady;
    inX  = inValid && (expectQ.size() < 2);
    if (outX) void'(expectQ.pop_front());
    if (inX)  expectQ.push_back(refExt(longint'(imm), 16, int'(mode)));
    @(negedge Clk);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear at once.
  task automatic pulseReset(input string tag);
    #2 Reset = 1'b0;
    #1;
    checkOutput({tag, "_outValid"}, {31'd0, bus.Out_Valid}, 32'd0);
    checkOutput({tag, "_inReady"}, {31'd0, bus.In_Ready}, 32'd1);
    checkOutput({tag, "_outData"}, bus.Out_Data, 32'd0);
    bus.In_Valid  = 1'b0;
    bus.Out_Ready = 1'b0;
    expectQ.delete();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    bus.In_Valid  = 1'b0;
    bus.In_Imm    = '0;
    bus.In_Mode   = '0;
    bus.Out_Ready = 1'b0;
    imm26         = '0;
    mode26        = '0;
    Reset         = 1'b1;
    @(negedge Clk);
    pulseReset("rst0");

    // Modes on known values, one cycle latency, consumer stalled.
    applyStimulus(1'b1, 16'h8004, 2'd0, 1'b0);
    checkOutput("sign8004", bus.Out_Data, 32'hFFFF8004);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b1, 16'h8004, 2'd1, 1'b0);
    checkOutput("zero8004", bus.Out_Data, 32'h00008004);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b1, 16'hFFFF, 2'd2, 1'b0);
    checkOutput("branchFFFF", bus.Out_Data, 32'hFFFFFFFC);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b1, 16'h1234, 2'd3, 1'b0);
    checkOutput("upper1234", bus.Out_Data, 32'h12340000);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);

    // 26-bit core sign extension and a few random modes.
    imm26  = 26'h2000000;
    mode26 = 2'd0;
    #1 checkOutput("core26sign", res26, 32'hFE000000);
    for (int i = 0; i < 8; i++) begin
      imm26  = 26'($urandom);
      mode26 = 2'($urandom_range(0, 3));
      #1 checkOutput("core26rand", res26, refExt(longint'(imm26), 26, int'(mode26)));
    end
    @(negedge Clk);

    // Back-pressure: fill both entries, hold a third, then drain.
    applyStimulus(1'b1, 16'h0001, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 2'd0, 1'b0);
    checkOutput("fullNotReady", {31'd0, bus.In_Ready}, 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h0003, 2'd0, 1'b0);
    checkOutput("stallHoldA", bus.Out_Data, 32'h00000001);
    applyStimulus(1'b1, 16'h0003, 2'd0, 1'b1);
    checkOutput("drainB", bus.Out_Data, 32'h00000002);
    applyStimulus(1'b1, 16'h0003, 2'd0, 1'b1);
    checkOutput("drainC", bus.Out_Data, 32'h00000003);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);

    // Streaming with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(i), 2'd1, 1'b1);
      checkOutput("streamData", bus.Out_Data, 32'(i));
    end
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);

    // Reset while both entries are full; nothing stale afterwards.
    applyStimulus(1'b1, 16'hAAAA, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 2'd1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0);
    pulseReset("rstTwo");
    applyStimulus(1'b1, 16'h7FFF, 2'd0, 1'b0);
    checkOutput("postReset", bus.Out_Data, 32'h00007FFF);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
